execute_cycle_muldiv: RTL and testbench

Parametrised execute stage for the 5-stage RISC-V pipeline, adding an RV32M/RV64M multiply/divide unit beside the single-cycle ALU. Forwarding muxes, branch resolution and the E/M pipeline register are XLEN-generic. Multi-cycle mul/div results are handed to the hazard unit through a stall handshake. Sits between the decode stage and the memory stage, replacing the fixed 32-bit execute stage.

---
 rtl/exec_pkg.sv | 44 ++++
 rtl/muldiv_unit.sv | 138 +++++++++++++
 rtl/execute_cycle_muldiv.sv | 136 +++++++++++++
 tb/tb_execute_cycle_muldiv.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU ops, branch compares,
// M-extension funct3 codes, mul/div FSM states and forwarding selects.
package exec_pkg;

  // ALUControlE encodings
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  // BranchE: funct3-coded, except 000 means "no branch", so BEQ moves to
  // the funct3 slot 010 that the base ISA leaves unused.
  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BEQ  = 3'b010;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  // MulDivOpE: RV32M/RV64M funct3
  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} mdState_t;

  // Forwarding selects (11 feeds zero)
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/muldiv_unit.sv
// Multi-cycle M-extension unit: one-cycle registered multiplier and a
// radix-2 restoring divider on magnitudes. Optional EXEC_DIV_EARLY_EXIT_EN
// lets trivial divides (zero divisor, overflow, |a|<|b|) skip iteration.
module muldiv_unit
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic            busy,
  output logic [XLEN-1:0] result
);
  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  mdState_t state, nextState;
  logic [CNT_W-1:0] cnt;
  logic [2:0] opQ;
  logic [XLEN-1:0] aQ, bQ, bMagQ, quotQ, remQ, resultQ;
  logic aNegQ, bNegQ;

  // Fix signs and force the architected special cases on a magnitude result
  function automatic logic [XLEN-1:0] divFinal(input logic [2:0] o,
      input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
      input logic [XLEN-1:0] qMag, input logic [XLEN-1:0] rMag,
      input logic aN, input logic bN);
    logic isRem;
    logic [XLEN-1:0] q, r;
    isRem = o[1];
    q = (aN ^ bN) ? -qMag : qMag;
    r = aN ? -rMag : rMag;
    if (b == '0)
      return isRem ? a : '1;
    if (!o[0] && a == MIN && b == '1)
      return isRem ? '0 : MIN;
    return isRem ? r : q;
  endfunction

  logic issue, isSigned, aNeg, bNeg;
  logic [XLEN-1:0] aMag, bMag;
  assign issue    = (state == ST_IDLE) && start && !flush;
  assign isSigned = op[2] && !op[0];
  assign aNeg     = isSigned && srcA[XLEN-1];
  assign bNeg     = isSigned && srcB[XLEN-1];
  assign aMag     = aNeg ? -srcA : srcA;
  assign bMag     = bNeg ? -srcB : srcB;

`ifdef EXEC_DIV_EARLY_EXIT_EN
  logic earlyExit;
  assign earlyExit = op[2] && ((srcB == '0) || (isSigned && srcA == MIN && srcB == '1) ||
                               (aMag < bMag));
`endif

  // Multiplier: operands extended per op so one unsigned 2*XLEN multiply covers all
  logic aSgn, bSgn;
  logic [2*XLEN-1:0] aExt, bExt, prod;
  assign aSgn = (opQ == MD_MULH) || (opQ == MD_MULHSU);
  assign bSgn = (opQ == MD_MULH);
  assign aExt = {{XLEN{aSgn & aQ[XLEN-1]}}, aQ};
  assign bExt = {{XLEN{bSgn & bQ[XLEN-1]}}, bQ};
  assign prod = aExt * bExt;

  // One restoring-division step: dividend bits shift out of quotQ into remQ
  logic [XLEN:0] remShift, diff;
  logic [XLEN-1:0] qNext, rNext;
  assign remShift = {remQ, quotQ[XLEN-1]};
  assign diff     = remShift - {1'b0, bMagQ};
  assign qNext    = {quotQ[XLEN-2:0], ~diff[XLEN]};
  assign rNext    = diff[XLEN] ? remShift[XLEN-1:0] : diff[XLEN-1:0];

  // FSM state register
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= ST_IDLE;
    else          state <= nextState;

  // Next state and busy; flush always wins and drops busy immediately
  always_comb begin
    nextState = state;
    busy      = 1'b0;
    case (state)
      ST_IDLE: if (start) begin
        busy      = 1'b1;
        nextState = op[2] ? ST_DIV : ST_MUL;
`ifdef EXEC_DIV_EARLY_EXIT_EN
        if (earlyExit) nextState = ST_DONE;
`endif
      end
      ST_MUL: begin busy = 1'b1; nextState = ST_DONE; end
      ST_DIV: begin busy = 1'b1; if (cnt == LAST) nextState = ST_DONE; end
      ST_DONE: nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
    if (flush) begin
      busy      = 1'b0;
      nextState = ST_IDLE;
    end
  end

  // Operand capture at issue, then multiply / iterate divide
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0; opQ <= '0; aQ <= '0; bQ <= '0; bMagQ <= '0;
      quotQ <= '0; remQ <= '0; resultQ <= '0; aNegQ <= 1'b0; bNegQ <= 1'b0;
    end else if (flush) begin
      cnt <= '0;
    end else if (issue) begin
      cnt   <= '0;
      opQ   <= op;
      aQ    <= srcA;
      bQ    <= srcB;
      bMagQ <= bMag;
      quotQ <= aMag;
      remQ  <= '0;
      aNegQ <= aNeg;
      bNegQ <= bNeg;
`ifdef EXEC_DIV_EARLY_EXIT_EN
      if (earlyExit) resultQ <= divFinal(op, srcA, srcB, '0, aMag, aNeg, bNeg);
`endif
    end else if (state == ST_MUL) begin
      resultQ <= (opQ == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end else if (state == ST_DIV) begin
      quotQ <= qNext;
      remQ  <= rNext;
      cnt   <= cnt + CNT_W'(1);
      if (cnt == LAST) resultQ <= divFinal(opQ, aQ, bQ, qNext, rNext, aNegQ, bNegQ);
    end
  end

  assign result = resultQ;

endmodule

// File: rtl/execute_cycle_muldiv.sv
// XLEN-generic execute stage: forwarding, ALU, branch resolution, E/M
// register, plus the multi-cycle muldiv_unit. Build option:
// EXEC_DIV_EARLY_EXIT_EN (passed through to muldiv_unit).
module execute_cycle_muldiv
  import exec_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            ALUSrcE,
  input  logic            JumpE,
  input  logic [1:0]      ResultSrcE,
  input  logic [2:0]      BranchE,
  input  logic [3:0]      ALUControlE,
  input  logic            MulDivE,
  input  logic [2:0]      MulDivOpE,
  input  logic            FlushE,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] Imm_Ext_E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [RA_W-1:0] RD_E,
  input  logic [1:0]      ForwardA_E,
  input  logic [1:0]      ForwardB_E,
  input  logic [XLEN-1:0] ResultW,
  output logic            StallE,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [RA_W-1:0] RD_M,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] ALU_ResultM
);
  localparam int SH_W = $clog2(XLEN);

  logic [XLEN-1:0] srcA, srcBInt, srcB, aluResult, mdResult, resultE;
  logic mdBusy, brTaken, bubble;

  // Forwarding muxes
  always_comb begin
    case (ForwardA_E)
      FWD_RF:  srcA = RD1_E;
      FWD_WB:  srcA = ResultW;
      FWD_MEM: srcA = ALU_ResultM;
      default: srcA = '0;
    endcase
    case (ForwardB_E)
      FWD_RF:  srcBInt = RD2_E;
      FWD_WB:  srcBInt = ResultW;
      FWD_MEM: srcBInt = ALU_ResultM;
      default: srcBInt = '0;
    endcase
  end

  assign srcB = ALUSrcE ? Imm_Ext_E : srcBInt;

  // Single-cycle ALU
  always_comb begin
    aluResult = '0;
    case (ALUControlE)
      ALU_ADD:  aluResult = srcA + srcB;
      ALU_SUB:  aluResult = srcA - srcB;
      ALU_AND:  aluResult = srcA & srcB;
      ALU_OR:   aluResult = srcA | srcB;
      ALU_XOR:  aluResult = srcA ^ srcB;
      ALU_SLT:  aluResult = {{(XLEN-1){1'b0}}, $signed(srcA) < $signed(srcB)};
      ALU_SLTU: aluResult = {{(XLEN-1){1'b0}}, srcA < srcB};
      ALU_SLL:  aluResult = srcA << srcB[SH_W-1:0];
      ALU_SRL:  aluResult = srcA >> srcB[SH_W-1:0];
      ALU_SRA:  aluResult = $signed(srcA) >>> srcB[SH_W-1:0];
      default:  aluResult = '0;
    endcase
  end

  // Branch compare on rs1/rs2 (never the immediate)
  always_comb begin
    brTaken = 1'b0;
    case (BranchE)
      BR_BEQ:  brTaken = (srcA == srcBInt);
      BR_BNE:  brTaken = (srcA != srcBInt);
      BR_BLT:  brTaken = ($signed(srcA) <  $signed(srcBInt));
      BR_BGE:  brTaken = ($signed(srcA) >= $signed(srcBInt));
      BR_BLTU: brTaken = (srcA <  srcBInt);
      BR_BGEU: brTaken = (srcA >= srcBInt);
      default: brTaken = 1'b0;
    endcase
  end

  assign PCTargetE = PCE + Imm_Ext_E;
  assign PCSrcE    = !MulDivE && (JumpE || brTaken);

  muldiv_unit #(.XLEN(XLEN)) uMulDiv (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (MulDivE),
    .flush   (FlushE),
    .op      (MulDivOpE),
    .srcA    (srcA),
    .srcB    (srcBInt),
    .busy    (mdBusy),
    .result  (mdResult)
  );

  // Stall is held off while in reset so the hazard unit never sees it
  assign StallE  = reset_n && mdBusy;
  assign resultE = MulDivE ? mdResult : aluResult;
  assign bubble  = StallE || FlushE;

  // E/M pipeline register; a bubble is an all-zero entry
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      RegWriteM <= 1'b0; MemWriteM <= 1'b0; ResultSrcM <= '0; RD_M <= '0;
      PCPlus4M <= '0; WriteDataM <= '0; ALU_ResultM <= '0;
    end else if (bubble) begin
      RegWriteM <= 1'b0; MemWriteM <= 1'b0; ResultSrcM <= '0; RD_M <= '0;
      PCPlus4M <= '0; WriteDataM <= '0; ALU_ResultM <= '0;
    end else begin
      RegWriteM   <= RegWriteE;
      MemWriteM   <= MemWriteE;
      ResultSrcM  <= ResultSrcE;
      RD_M        <= RD_E;
      PCPlus4M    <= PCPlus4E;
      WriteDataM  <= srcBInt;
      ALU_ResultM <= resultE;
    end
  end

endmodule

// File: tb/tb_execute_cycle_muldiv.sv
// Directed bench for execute_cycle_muldiv (XLEN=32); expected values are
// hand-computed. Divide stall counts follow EXEC_DIV_EARLY_EXIT_EN.
module tb_execute_cycle_muldiv;
  import exec_pkg::*;
  localparam int XLEN = 32;
  localparam int RA_W = 5;
`ifdef EXEC_DIV_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic clock = 1'b0, reset_n;
  logic RegWriteE, MemWriteE, ALUSrcE, JumpE, MulDivE, FlushE;
  logic [1:0] ResultSrcE, ForwardA_E, ForwardB_E;
  logic [2:0] BranchE, MulDivOpE;
  logic [3:0] ALUControlE;
  logic [XLEN-1:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [RA_W-1:0] RD_E;
  logic StallE, PCSrcE, RegWriteM, MemWriteM;
  logic [XLEN-1:0] PCTargetE, PCPlus4M, WriteDataM, ALU_ResultM;
  logic [1:0] ResultSrcM;
  logic [RA_W-1:0] RD_M;

  int nCmp = 0, nErr = 0;

  execute_cycle_muldiv #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clock(clock), .reset_n(reset_n), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .ALUSrcE(ALUSrcE), .JumpE(JumpE), .ResultSrcE(ResultSrcE), .BranchE(BranchE),
    .ALUControlE(ALUControlE), .MulDivE(MulDivE), .MulDivOpE(MulDivOpE), .FlushE(FlushE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .RD_E(RD_E), .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .ResultW(ResultW),
    .StallE(StallE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
    .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCmp++;
    if (obs !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic idleIns();
    RegWriteE = 0; MemWriteE = 0; ALUSrcE = 0; JumpE = 0; MulDivE = 0; FlushE = 0;
    ResultSrcE = 0; ForwardA_E = FWD_RF; ForwardB_E = FWD_RF; BranchE = BR_NONE;
    MulDivOpE = 0; ALUControlE = ALU_ADD; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0;
    PCE = 0; PCPlus4E = 0; ResultW = 0; RD_E = 0;
  endtask

  task automatic aluOp(input string tag, input logic [3:0] ctl,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] expd);
    ALUControlE = ctl; RD1_E = a; RD2_E = b; RegWriteE = 1; RD_E = 5'd3;
    #1 chk({tag, " StallE"}, StallE, 0);
    step();
    chk({tag, " result"}, ALU_ResultM, expd);
    chk({tag, " RegWriteM"}, RegWriteM, 1);
  endtask

  function automatic int divStall(input bit early);
    return (early && EE) ? 1 : XLEN + 1;
  endfunction

  // Issue a mul/div, hold E like the hazard unit, count stall cycles
  task automatic runMd(input string tag, input logic [2:0] op,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] expd, input int expStall);
    int n;
    n = 0;
    MulDivE = 1; MulDivOpE = op; RD1_E = a; RD2_E = b; RegWriteE = 1; RD_E = 5'd7;
    ForwardA_E = FWD_RF; ForwardB_E = FWD_RF;
    #1;
    while (StallE === 1'b1 && n < 100) begin
      n++;
      step();
      if (n == 1) begin
        chk({tag, " bubble RegWriteM"}, RegWriteM, 0);
        RD1_E = 32'h1357_9BDF; RD2_E = 32'h2468_ACE0;  // must be ignored
      end
      #1;
    end
    chk({tag, " stall cycles"}, 64'(n), 64'(expStall));
    step();
    chk({tag, " result"}, ALU_ResultM, expd);
    chk({tag, " RegWriteM"}, RegWriteM, 1);
    chk({tag, " RD_M"}, RD_M, 7);
    MulDivE = 0; RegWriteE = 0; RD_E = 0;
  endtask

  initial begin
    idleIns();
    reset_n = 0;
    #12;
    chk("reset StallE", StallE, 0);
    chk("reset RegWriteM", RegWriteM, 0);
    chk("reset ALU_ResultM", ALU_ResultM, 0);
    chk("reset RD_M", RD_M, 0);
    @(negedge clock) reset_n = 1;
    step();

    // ALU path and forwarding
    aluOp("ADD 4+5", ALU_ADD, 4, 5, 9);
    ForwardA_E = FWD_MEM; RD1_E = 100;
    ALUControlE = ALU_ADD; RD2_E = 7; RegWriteE = 1;
    #1 chk("ADD fwd MEM StallE", StallE, 0);
    step();
    chk("ADD fwd MEM 9+7", ALU_ResultM, 16);
    ForwardA_E = FWD_RF;
    aluOp("SUB 3-5", ALU_SUB, 3, 5, 32'hFFFF_FFFE);
    aluOp("SLT -1<1", ALU_SLT, 32'hFFFF_FFFF, 1, 1);
    aluOp("SLTU big<1", ALU_SLTU, 32'hFFFF_FFFF, 1, 0);
    aluOp("SRA", ALU_SRA, 32'h8000_0000, 4, 32'hF800_0000);
    ForwardB_E = FWD_WB; ResultW = 32'h40; PCPlus4E = 32'h104;
    aluOp("ADD fwd WB", ALU_ADD, 2, 32'h999, 32'h42);
    chk("fwd WB WriteDataM", WriteDataM, 32'h40);
    chk("PCPlus4M", PCPlus4M, 32'h104);
    ForwardB_E = 2'b11; ForwardA_E = 2'b11;
    aluOp("fwd sel 11 zero", ALU_ADD, 5, 5, 0);
    ForwardA_E = FWD_RF; ForwardB_E = FWD_RF;
    ALUSrcE = 1; Imm_Ext_E = 32'h10;
    aluOp("ADDI", ALU_ADD, 1, 32'h77, 32'h11);
    chk("ADDI WriteDataM", WriteDataM, 32'h77);
    idleIns();

    // Multiplies
    runMd("MULH min*min", MD_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);
    runMd("MUL 3*4", MD_MUL, 3, 4, 12, 2);
    runMd("MUL low -1*-1", MD_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 2);
    runMd("MULHU", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    runMd("MULHSU -1*2", MD_MULHSU, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFF, 2);

    // Divides
    runMd("DIV -7/2", MD_DIV, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, divStall(0));
    runMd("REM -7/2", MD_REM, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, divStall(0));
    runMd("DIV 7/-2", MD_DIV, 7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, divStall(0));
    runMd("REM 7/-2", MD_REM, 7, 32'hFFFF_FFFE, 1, divStall(0));
    runMd("DIVU 100/7", MD_DIVU, 100, 7, 14, divStall(0));
    runMd("REMU 100/7", MD_REMU, 100, 7, 2, divStall(0));
    runMd("DIVU max/1", MD_DIVU, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, divStall(0));
    runMd("DIVU 100/0", MD_DIVU, 100, 0, 32'hFFFF_FFFF, divStall(1));
    runMd("REMU 100/0", MD_REMU, 100, 0, 100, divStall(1));
    runMd("DIV min/-1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, divStall(1));
    runMd("REM min/-1", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, divStall(1));
    runMd("DIVU 3/100", MD_DIVU, 3, 100, 0, divStall(1));
    runMd("REM -3/100", MD_REM, 32'hFFFF_FFFD, 100, 32'hFFFF_FFFD, divStall(1));

    // Flush at divide iteration 10
    MulDivE = 1; MulDivOpE = MD_DIVU; RD1_E = 100; RD2_E = 7; RegWriteE = 1; RD_E = 5'd9;
    step();
    for (int i = 0; i < 10; i++) step();
    chk("flush pre StallE", StallE, 1);
    FlushE = 1;
    #1 chk("flush StallE drop", StallE, 0);
    step();
    chk("flush RegWriteM", RegWriteM, 0);
    idleIns();
    step();
    chk("post-flush StallE", StallE, 0);
    chk("post-flush RegWriteM", RegWriteM, 0);
    runMd("MUL after flush", MD_MUL, 3, 4, 12, 2);

    // Async reset clears a live E/M entry
    PCPlus4E = 32'h200;
    aluOp("ADD 20+22", ALU_ADD, 20, 22, 42);
    RegWriteE = 0;
    reset_n = 0;
    #1;
    chk("rst ALU_ResultM", ALU_ResultM, 0);
    chk("rst RegWriteM", RegWriteM, 0);
    chk("rst PCPlus4M", PCPlus4M, 0);
    reset_n = 1;
    idleIns();
    step();

    // Reset in the middle of a multiply
    MulDivE = 1; MulDivOpE = MD_MUL; RD1_E = 5; RD2_E = 6; RegWriteE = 1; RD_E = 5'd4;
    step();
    chk("mid-MUL StallE", StallE, 1);
    reset_n = 0;
    #1;
    chk("rst mid-MUL StallE", StallE, 0);
    chk("rst mid-MUL RegWriteM", RegWriteM, 0);
    chk("rst mid-MUL RD_M", RD_M, 0);
    idleIns();
    reset_n = 1;
    #1 chk("after rst FSM idle", StallE, 0);
    step();
    chk("after rst no writeback", RegWriteM, 0);

    // Branch resolution
    RD1_E = 32'h1234; RD2_E = 32'h1234; PCE = 32'h100; Imm_Ext_E = 32'h20;
    BranchE = BR_BEQ;
    #1;
    chk("BEQ taken", PCSrcE, 1);
    chk("PCTargetE", PCTargetE, 32'h120);
    BranchE = BR_NONE;
    #1 chk("BranchE none", PCSrcE, 0);
    BranchE = BR_BNE;
    #1 chk("BNE equal", PCSrcE, 0);
    RD1_E = 32'hFFFF_FFFF; RD2_E = 1; BranchE = BR_BLT;
    #1 chk("BLT -1<1", PCSrcE, 1);
    BranchE = BR_BLTU;
    #1 chk("BLTU big<1", PCSrcE, 0);
    BranchE = BR_NONE; JumpE = 1;
    #1 chk("JAL", PCSrcE, 1);
    PCE = 32'hFFFF_FFF0; Imm_Ext_E = 32'h20;
    #1 chk("PCTargetE wrap", PCTargetE, 32'h10);
    MulDivE = 1; FlushE = 1;
    #1 chk("jump masked by MulDivE", PCSrcE, 0);
    idleIns();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
